sevenseg_scan_driver: RTL and testbench
=======================================

// Module: sevenseg_scan_driver
// PURPOSE
//  Time-multiplexes three 7-segment digit patterns onto one shared segment bus and three digit anodes.
//  Sits directly downstream of the 8-bit-to-three-digit seven-segment decoder and drives the board pins.
//  Latches all three digits at the start of each frame, so a displayed frame never mixes two input values.
//  Inserts dead time between digits to suppress ghosting.
// PARAMETERS
//  SLOT_CYCLES    8000        clk cycles per digit slot (dead time + drive); >= 2
//  DEAD_CYCLES    200         cycles per slot with all anodes off; 0 <= DEAD_CYCLES < SLOT_CYCLES
//  SEG_ACTIVE_LOW 1           1: seg_out inverted at the pin (0 = segment lit)
//  AN_ACTIVE_LOW  1           1: anode_out inverted at the pin (0 = digit on)
// PORTS
//  clk                input   1  system clock
//  rst_n              input   1  asynchronous active-low reset
//  en                 input   1  1 = scan, 0 = display dark
//  hundreds_sevenseg  input   7  active-high pattern, bit0=a .. bit6=g
//  tens_sevenseg      input   7  same encoding
//  ones_sevenseg      input   7  same encoding
//  seg_out            output  7  shared segment bus, polarity per SEG_ACTIVE_LOW
//  anode_out          output  3  [0]=ones, [1]=tens, [2]=hundreds; polarity per AN_ACTIVE_LOW
//  frame_start        output  1  one-cycle pulse when a new snapshot is taken
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, counters 0, snapshots 0, frame_start 0, all outputs OFF.
//    OFF means all segments dark and all anodes off. With the defaults that is seg_out=7'h7F, anode_out=3'b111.
//  - FSM states: IDLE, BLANK, DRIVE. Digit index idx runs 0=ones, 1=tens, 2=hundreds.
//  - IDLE -> BLANK(idx=0) when en=1. This transition takes the snapshot and pulses frame_start.
//  - BLANK: holds DEAD_CYCLES cycles with all anodes off, then goes to DRIVE. If DEAD_CYCLES=0, BLANK is skipped.
//  - DRIVE: holds SLOT_CYCLES-DEAD_CYCLES cycles with anode[idx] on and seg_out = snapshot[idx].
//    It then goes to BLANK(idx+1).
//  - Wrap: after idx=2, return to BLANK(idx=0), re-snapshot and pulse frame_start. Frame length = 3*SLOT_CYCLES.
//  - en=0 in any state: IDLE on the next clk, outputs OFF on the following cycle. The snapshot is retained.
//  - All outputs are registered and change 1 cycle after the state or counter event.
//    First lit segment appears DEAD_CYCLES+1 cycles after frame_start.
//  - Input changes mid-frame are ignored until the next snapshot.
//  - Slot counter width is $clog2(SLOT_CYCLES). It counts 0..SLOT_CYCLES-1 and never free-runs past the terminal count.
//  - Polarity inversion is applied only at the output register; internal data stays active-high.
// CONFIGURATION
//  - LEADING_ZERO_BLANK_EN defined: at snapshot, if hundreds == ZERO_PATTERN the hundreds slot is blanked.
//    If the hundreds slot is blanked and tens == ZERO_PATTERN, the tens slot is blanked too.
//    The ones digit is never blanked.
//  - A blanked slot keeps its full timing, with its anode off and segments OFF.
//  - LEADING_ZERO_BLANK_EN undefined: every digit is driven as captured.
// STRUCTURE
//  - Package sevenseg_pkg holds:
//    * ZERO_PATTERN = 7'b0111111 (active-high, a..f lit, g dark)
//    * SEG_DARK = 7'h00
//    * typedef enum state_t {IDLE, BLANK, DRIVE}
//    * typedef logic [1:0] digit_idx_t
//  - One sub-module, sevenseg_slot_timer: the slot counter with load/clear and done_dead / done_slot strobes.
//    The FSM, snapshot registers and output registers stay in the top module.
// TESTING (bench params: SLOT_CYCLES=8, DEAD_CYCLES=2, both polarities active-low)
//  1. Reset: rst_n=0 asserted mid-DRIVE -> seg_out=7'h7F and anode_out=3'b111 immediately, with no clk edge.
//     Release with en=0 -> outputs stay OFF.
//  2. Scan: inputs ones=7'h06, tens=7'h5B, hundreds=7'h4F; raise en -> frame_start pulses once.
//     anode_out then reads 111 x2, 110 x6, 111 x2, 101 x6, 111 x2, 011 x6, with seg_out = ~pattern while driven.
//     frame_start repeats every 24 cycles.
//  3. Snapshot coherence: change all inputs 4 cycles into the tens DRIVE slot.
//     Old values hold through the hundreds slot; new values appear only in the next frame.
//  4. Enable drop: en=0 during ones DRIVE -> all outputs OFF within 2 cycles.
//     Re-raising en -> new frame_start, scan restarts at ones.
//  5. LEADING_ZERO_BLANK_EN: input 007 -> hundreds and tens slots stay 111 on anodes; input 070 -> only hundreds blanked.
//     Input 000 -> ones still shows ZERO_PATTERN.
//     Macro undefined: all three digits driven in every case.
//  6. DEAD_CYCLES=0 build: anode_out steps 110 -> 101 -> 011 with no all-off gaps, 8 cycles each.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-high, bit0=a .. bit6=g.
package sevenseg_pkg;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] ZERO_PATTERN = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_DARK     = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Digit index: 0=ones, 1=tens, 2=hundreds
  typedef logic [1:0] digit_idx_t;

  // Captured frame: [0]=ones, [1]=tens, [2]=hundreds
  typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] digit_set_t;

endpackage

// File: rtl/sevenseg_slot_timer.sv
// Slot counter for the scan driver. Counts 0..SLOT_CYCLES-1 and wraps to 0,
// never running past the terminal count.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clr            synchronous clear to 0 (wins over counting)
//   done_dead_c    high on the last dead-time cycle of a slot (never if DEAD_CYCLES=0)
//   done_slot_c    high on the last cycle of a slot
module sevenseg_slot_timer #(
  parameter int unsigned SLOT_CYCLES = 8000,
  parameter int unsigned DEAD_CYCLES = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic done_dead_c,
  output logic done_slot_c
);

  localparam int unsigned CNT_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned DEAD_LAST = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;
  localparam bit          HAS_DEAD  = (DEAD_CYCLES > 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_slot_c = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
  assign done_dead_c = HAS_DEAD && (cnt_q == CNT_W'(DEAD_LAST));

  // Next count: clear, wrap at terminal count, else increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (done_slot_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexes three seven-segment digits onto one segment bus and three
// anodes, with dead time between digits. All three digits are snapshotted at
// frame start so a frame never mixes two input values.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (hundreds, then tens); the ones digit is always shown.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   en                    1 = scan, 0 = display dark
//   *_sevenseg            active-high digit patterns, bit0=a .. bit6=g
//   seg_out               shared segment bus, polarity per SEG_ACTIVE_LOW
//   anode_out             [0]=ones [1]=tens [2]=hundreds, polarity per AN_ACTIVE_LOW
//   frame_start           one-cycle pulse when a new snapshot is taken
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES    = 8000,
  parameter int unsigned DEAD_CYCLES    = 200,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEG_W-1:0] hundreds_sevenseg,
  input  logic [SEG_W-1:0] tens_sevenseg,
  input  logic [SEG_W-1:0] ones_sevenseg,
  output logic [SEG_W-1:0] seg_out,
  output logic [2:0]       anode_out,
  output logic             frame_start
);

  // With no dead time, each slot starts directly in DRIVE
  localparam state_t           SLOT_ENTRY = (DEAD_CYCLES == 0) ? DRIVE : BLANK;
  localparam logic [SEG_W-1:0] SEG_OFF    = SEG_ACTIVE_LOW ? ~SEG_DARK : SEG_DARK;
  localparam logic [2:0]       AN_OFF     = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  state_t           state_q, state_d;
  digit_idx_t       idx_q, idx_d;
  digit_set_t       snap_q, snap_d;
  logic             frame_start_q, frame_start_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [2:0]       anode_q, anode_d;
  logic [SEG_W-1:0] seg_lit_c;
  logic [2:0]       an_lit_c;
  logic [2:0]       blank_c;
  logic             take_snap_c;
  logic             timer_clr_c;
  logic             done_dead_c;
  logic             done_slot_c;

  sevenseg_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_slot_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (timer_clr_c),
    .done_dead_c (done_dead_c),
    .done_slot_c (done_slot_c)
  );

  // Next state, digit index and snapshot strobe
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    take_snap_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d     = SLOT_ENTRY;
          idx_d       = '0;
          take_snap_c = 1'b1;
        end
      end
      BLANK: begin
        if (done_dead_c) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (done_slot_c) begin
          state_d = SLOT_ENTRY;
          if (idx_q == digit_idx_t'(2)) begin
            idx_d       = '0;
            take_snap_c = 1'b1;
          end else begin
            idx_d = idx_q + digit_idx_t'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    // Enable drop overrides everything; snapshot is retained
    if (!en) begin
      state_d     = IDLE;
      idx_d       = '0;
      take_snap_c = 1'b0;
    end
    // Counter holds at 0 while idle so each frame starts at slot phase 0
    timer_clr_c   = !en || (state_q == IDLE);
    frame_start_d = take_snap_c;
    snap_d        = take_snap_c ? {hundreds_sevenseg, tens_sevenseg, ones_sevenseg} : snap_q;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] blank_q, blank_d;

  // Leading-zero flags are decided once per frame, at snapshot time
  always_comb begin
    blank_d = blank_q;
    if (take_snap_c) begin
      blank_d[2] = (hundreds_sevenseg == ZERO_PATTERN);
      blank_d[1] = blank_d[2] && (tens_sevenseg == ZERO_PATTERN);
      blank_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank_c = blank_q;
`else
  assign blank_c = '0;
`endif

  // Output data from the current state; polarity applied only here
  always_comb begin
    seg_lit_c = SEG_DARK;
    an_lit_c  = 3'b000;
    if ((state_q == DRIVE) && !blank_c[idx_q]) begin
      seg_lit_c = snap_q[idx_q];
      an_lit_c  = 3'b001 << idx_q;
    end
    seg_d   = SEG_ACTIVE_LOW ? ~seg_lit_c : seg_lit_c;
    anode_d = AN_ACTIVE_LOW ? ~an_lit_c : an_lit_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      snap_q        <= '0;
      frame_start_q <= 1'b0;
      seg_q         <= SEG_OFF;
      anode_q       <= AN_OFF;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      anode_q       <= anode_d;
    end
  end

  assign seg_out     = seg_q;
  assign anode_out   = anode_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: two instances (dead time 2 and 0, slot 8,
// active-low pins) share stimulus and are checked every cycle against a
// frame-position model of the display.
module tb_sevenseg_scan_driver;

  localparam int SLOT  = 8;
  localparam int FRAME = 3 * SLOT;
  localparam logic [6:0] ZERO = 7'b0111111;
  localparam logic [6:0] OFF_SEG = 7'h7F;
  localparam logic [2:0] OFF_AN  = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [6:0] hund_i, tens_i, ones_i;
  logic [6:0] seg0, seg1;
  logic [2:0] an0, an1;
  logic       fs0, fs1;

  int n_checks = 0;
  int n_errors = 0;

  // Model: running flag, position within frame, captured digits, blank flags
  bit         m_run   [2];
  int         m_t     [2];
  logic [6:0] m_snap  [2][3];
  bit         m_blank [2][3];
  logic [6:0] e_seg   [2];
  logic [2:0] e_an    [2];
  logic       e_fs    [2];

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .SLOT_CYCLES(8), .DEAD_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hundreds_sevenseg(hund_i), .tens_sevenseg(tens_i), .ones_sevenseg(ones_i),
    .seg_out(seg0), .anode_out(an0), .frame_start(fs0)
  );

  sevenseg_scan_driver #(
    .SLOT_CYCLES(8), .DEAD_CYCLES(0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_nd (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hundreds_sevenseg(hund_i), .tens_sevenseg(tens_i), .ones_sevenseg(ones_i),
    .seg_out(seg1), .anode_out(an1), .frame_start(fs1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0;
      m_t[k]   = 0;
      for (int d = 0; d < 3; d++) begin
        m_snap[k][d]  = 7'h00;
        m_blank[k][d] = 1'b0;
      end
      e_seg[k] = OFF_SEG;
      e_an[k]  = OFF_AN;
      e_fs[k]  = 1'b0;
    end
  endtask

  // One clock edge: outputs reflect the display position before the edge
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int dead;
      int d;
      dead = (k == 0) ? 2 : 0;
      d    = m_t[k] / SLOT;
      if (m_run[k] && ((m_t[k] % SLOT) >= dead) && !m_blank[k][d]) begin
        e_seg[k] = ~m_snap[k][d];
        e_an[k]  = ~(3'b001 << d);
      end else begin
        e_seg[k] = OFF_SEG;
        e_an[k]  = OFF_AN;
      end
      e_fs[k] = 1'b0;
      if (!en) begin
        m_run[k] = 1'b0;
      end else if (!m_run[k] || (m_t[k] == FRAME - 1)) begin
        m_run[k] = 1'b1;
        m_t[k]   = 0;
        e_fs[k]  = 1'b1;
        m_snap[k][0] = ones_i;
        m_snap[k][1] = tens_i;
        m_snap[k][2] = hund_i;
        m_blank[k][0] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        m_blank[k][2] = (hund_i == ZERO);
        m_blank[k][1] = m_blank[k][2] && (tens_i == ZERO);
`else
        m_blank[k][2] = 1'b0;
        m_blank[k][1] = 1'b0;
`endif
      end else begin
        m_t[k] = m_t[k] + 1;
      end
    end
  endtask

  task automatic check_all();
    check("seg_d2",  32'(seg0), 32'(e_seg[0]));
    check("an_d2",   32'(an0),  32'(e_an[0]));
    check("fs_d2",   32'(fs0),  32'(e_fs[0]));
    check("seg_d0",  32'(seg1), 32'(e_seg[1]));
    check("an_d0",   32'(an1),  32'(e_an[1]));
    check("fs_d0",   32'(fs1),  32'(e_fs[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_digits(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o);
    hund_i = h;
    tens_i = t;
    ones_i = o;
  endtask

  // Advance until the dead-time instance reaches frame position pos (bounded)
  task automatic seek(input int pos);
    int i;
    i = 0;
    while (!(m_run[0] && m_t[0] == pos) && i < 4 * FRAME) begin
      tick();
      i++;
    end
    check("seek_pos", 32'(m_run[0] && m_t[0] == pos), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    set_digits(7'h00, 7'h00, 7'h00);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (4) tick();

    // Basic scan of 3-2-1 over two frames
    set_digits(7'h4F, 7'h5B, 7'h06);
    en = 1'b1;
    repeat (2 * FRAME + 2) tick();

    // Inputs change 4 cycles into the tens drive slot
    seek(SLOT + 2 + 4);
    set_digits(7'h7D, 7'h66, 7'h3F);
    repeat (2 * FRAME) tick();

    // Enable drop during ones drive, then restart
    seek(2 + 2);
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    repeat (FRAME + 4) tick();

    // Leading-zero patterns: 007, 070, 000
    set_digits(ZERO, ZERO, 7'h07);
    repeat (FRAME + 2) tick();
    seek(0);
    repeat (FRAME) tick();
    set_digits(ZERO, 7'h07, ZERO);
    seek(0);
    repeat (FRAME) tick();
    set_digits(ZERO, ZERO, ZERO);
    seek(0);
    repeat (FRAME) tick();

    // Async reset mid-drive: outputs go dark with no clock edge
    set_digits(7'h4F, 7'h5B, 7'h06);
    seek(2 + 3);
    rst_n = 1'b0;
    #1;
    check("rst_seg_d2", 32'(seg0), 32'(OFF_SEG));
    check("rst_an_d2",  32'(an0),  32'(OFF_AN));
    check("rst_fs_d2",  32'(fs0),  32'd0);
    check("rst_seg_d0", 32'(seg1), 32'(OFF_SEG));
    check("rst_an_d0",  32'(an1),  32'(OFF_AN));
    model_reset();
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();

    // Randomized traffic
    en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        hund_i = ($urandom_range(0, 2) == 0) ? ZERO : 7'($urandom);
        tens_i = ($urandom_range(0, 2) == 0) ? ZERO : 7'($urandom);
        ones_i = 7'($urandom);
      end
      en = ($urandom_range(0, 39) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
